// File: rtl/dest_rd_cred_sched_pkg.sv
// Shared types and constants for the per-destination read-credit scheduler.
// Contents: response beat size and the scheduler FSM state type.
package dest_rd_cred_sched_pkg;

    // One response beat carries 64 bytes.
    localparam int unsigned RD_CRED_BEAT_BYTES = 64;
    localparam int unsigned RD_CRED_BEAT_SHIFT = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_sched_state_t;

endpackage

// File: rtl/dest_rd_cred_sched_if.sv
// Request-side bundle of the read-credit scheduler.
// Carries per-destination request valid/ready/len, the forwarded request
// (valid/ready/dest/len) and the per-destination response beat drain pulses.
// slave  : scheduler view.
// master : requester / downstream / response-FIFO view.
interface dest_rd_cred_sched_if #(
    parameter int unsigned N_DESTS  = 4,
    parameter int unsigned LEN_BITS = 28
);
    localparam int unsigned DEST_W = (N_DESTS > 1) ? $clog2(N_DESTS) : 1;

    logic [N_DESTS-1:0]          s_req_valid;
    logic [N_DESTS-1:0]          s_req_ready;
    logic [N_DESTS*LEN_BITS-1:0] s_req_len;
    logic                        m_req_valid;
    logic                        m_req_ready;
    logic [DEST_W-1:0]           m_req_dest;
    logic [LEN_BITS-1:0]         m_req_len;
    logic [N_DESTS-1:0]          xfer;

    modport slave (
        input  s_req_valid, s_req_len, m_req_ready, xfer,
        output s_req_ready, m_req_valid, m_req_dest, m_req_len
    );

    modport master (
        output s_req_valid, s_req_len, m_req_ready, xfer,
        input  s_req_ready, m_req_valid, m_req_dest, m_req_len
    );

endinterface

// File: rtl/dest_rd_cred_sched_rr_arb.sv
// rd_cred_rr_arb: combinational N-way round-robin pick.
// Ports: req (request vector), ptr (highest-priority index),
//        gnt_idx (first requesting index at/after ptr, wrapping), gnt_any.
module rd_cred_rr_arb #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_any && req[IW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/dest_rd_cred_sched.sv
// dest_rd_cred_sched: read-request scheduler with per-destination response
// beat credits. Forwards one request at a time, round-robin among
// destinations whose credits cover the request; credits return on xfer.
// Ports: aclk, aresetn (async, active low), bus (dest_rd_cred_sched_if.slave),
//        err_oversize (sticky per-destination oversize flag),
//        stall_cnt (only with RD_CRED_STATS_EN: per-destination credit-stall
//        cycle counters, 32 bits each, packed).
module dest_rd_cred_sched
    import dest_rd_cred_sched_pkg::*;
#(
    parameter int unsigned N_DESTS  = 4,
    parameter int unsigned CRED_MAX = 512,
    parameter int unsigned LEN_BITS = 28
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    dest_rd_cred_sched_if.slave    bus,
    output logic [N_DESTS-1:0]     err_oversize
`ifdef RD_CRED_STATS_EN
    ,
    output logic [N_DESTS*32-1:0]  stall_cnt
`endif
);

    localparam int unsigned DEST_W = (N_DESTS > 1) ? $clog2(N_DESTS) : 1;
    localparam int unsigned CW     = $clog2(CRED_MAX + 1);
    localparam int unsigned BW     = LEN_BITS + 1;

    rd_sched_state_t     state_q, state_d;
    logic [DEST_W-1:0]   ptr_q, ptr_d;
    logic                m_valid_q, m_valid_d;
    logic [DEST_W-1:0]   m_dest_q, m_dest_d;
    logic [LEN_BITS-1:0] m_len_q, m_len_d;
    logic [N_DESTS-1:0]  ready_q, ready_d;
    logic [N_DESTS-1:0]  err_q, err_d;
    logic [CW-1:0]       cred_q [N_DESTS];
    logic [CW-1:0]       cred_d [N_DESTS];

    logic [LEN_BITS-1:0] len_c     [N_DESTS];
    logic [BW-1:0]       beats_c   [N_DESTS];
    logic [N_DESTS-1:0]  eligible_c;
    logic [N_DESTS-1:0]  oversize_c;
    logic [N_DESTS-1:0]  grant_c;
    logic [DEST_W-1:0]   ov_idx_c;
    logic [DEST_W-1:0]   gnt_idx_c;
    logic                gnt_any_c;

    // Beat count per request and qualification. A destination whose
    // ready pulse is already out is masked so its request is not seen twice.
    always_comb begin
        ov_idx_c = '0;
        for (int i = 0; i < int'(N_DESTS); i++) begin
            len_c[i] = bus.s_req_len[i*LEN_BITS +: LEN_BITS];
            if (len_c[i] == '0) begin
                beats_c[i] = BW'(1);
            end else begin
                beats_c[i] = (BW'(len_c[i]) + BW'(RD_CRED_BEAT_BYTES - 1)) >> RD_CRED_BEAT_SHIFT;
            end
            eligible_c[i] = bus.s_req_valid[i] && !ready_q[i] && (beats_c[i] <= BW'(cred_q[i]));
            oversize_c[i] = bus.s_req_valid[i] && !ready_q[i] && (beats_c[i] > BW'(CRED_MAX));
        end
        for (int i = int'(N_DESTS) - 1; i >= 0; i--) begin
            if (oversize_c[i]) begin
                ov_idx_c = DEST_W'(i);
            end
        end
    end

    rd_cred_rr_arb #(
        .N (N_DESTS)
    ) u_arb (
        .req     (eligible_c),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx_c),
        .gnt_any (gnt_any_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        m_valid_d = m_valid_q;
        m_dest_d  = m_dest_q;
        m_len_d   = m_len_q;
        ready_d   = '0;
        err_d     = err_q;
        grant_c   = '0;
        case (state_q)
            IDLE: begin
                if (|oversize_c) begin
                    ready_d[ov_idx_c] = 1'b1;
                    err_d[ov_idx_c]   = 1'b1;
                end else if (gnt_any_c) begin
                    ready_d[gnt_idx_c] = 1'b1;
                    grant_c[gnt_idx_c] = 1'b1;
                    m_valid_d          = 1'b1;
                    m_dest_d           = gnt_idx_c;
                    m_len_d            = len_c[gnt_idx_c];
                    ptr_d              = (gnt_idx_c == DEST_W'(N_DESTS - 1)) ? '0
                                                                             : gnt_idx_c + DEST_W'(1);
                    state_d            = SEND;
                end
            end
            SEND: begin
                if (bus.m_req_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit net update; a return at full credit without a grant is dropped.
    always_comb begin
        for (int i = 0; i < int'(N_DESTS); i++) begin
            cred_d[i] = cred_q[i];
            if (grant_c[i]) begin
                cred_d[i] = cred_d[i] - CW'(beats_c[i]);
            end
            if (bus.xfer[i] && (grant_c[i] || (cred_q[i] != CW'(CRED_MAX)))) begin
                cred_d[i] = cred_d[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_dest_q  <= '0;
            m_len_q   <= '0;
            ready_q   <= '0;
            err_q     <= '0;
            for (int i = 0; i < int'(N_DESTS); i++) begin
                cred_q[i] <= CW'(CRED_MAX);
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            m_valid_q <= m_valid_d;
            m_dest_q  <= m_dest_d;
            m_len_q   <= m_len_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            for (int i = 0; i < int'(N_DESTS); i++) begin
                cred_q[i] <= cred_d[i];
            end
        end
    end

    assign bus.s_req_ready = ready_q;
    assign bus.m_req_valid = m_valid_q;
    assign bus.m_req_dest  = m_dest_q;
    assign bus.m_req_len   = m_len_q;
    assign err_oversize    = err_q;

    // A drain pulse at full credit means the response FIFO returned more
    // beats than were ever granted.
    for (genvar gi = 0; gi < int'(N_DESTS); gi++) begin : g_xfer_chk
        a_xfer_full: assert property (@(posedge aclk) disable iff (!aresetn)
            !(bus.xfer[gi] && !grant_c[gi] && (cred_q[gi] == CW'(CRED_MAX))));
    end

`ifdef RD_CRED_STATS_EN
    logic [N_DESTS-1:0] stall_c;
    logic [31:0]        stall_q [N_DESTS];

    // Credit stall: request fits the FIFO but not the current credits.
    always_comb begin
        for (int i = 0; i < int'(N_DESTS); i++) begin
            stall_c[i] = bus.s_req_valid[i] && (beats_c[i] > BW'(cred_q[i]))
                         && (beats_c[i] <= BW'(CRED_MAX));
            stall_cnt[i*32 +: 32] = stall_q[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(N_DESTS); i++) begin
                stall_q[i] <= '0;
            end
        end else if (state_q == IDLE) begin
            for (int i = 0; i < int'(N_DESTS); i++) begin
                if (stall_c[i] && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + 32'(1);
                end
            end
        end
    end
`endif

endmodule

// File: doc/dest_rd_cred_sched.md
Name: dest_rd_cred_sched

Overview:
- Read-request scheduler for the per-destination remote read path, placed in front of the shared read-request output.
- Holds one response-beat credit counter per destination, sized to that destination's response data FIFO.
- Forwards one queued read request at a time, chosen round-robin among destinations whose credits cover the request's beats.
- Replenishes a destination's credits as its response beats drain from the response FIFO.

Parameters:
N_DESTS, 4, number of requesting destinations (1..16)
CRED_MAX, 512, response FIFO depth in 64-byte beats; reset credit value per destination
LEN_BITS, 28, width of request length in bytes

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_req_valid  in  N_DESTS  per-destination request valid
s_req_ready  out  N_DESTS  per-destination request accept
s_req_len  in  N_DESTS*LEN_BITS  packed request byte lengths, dest i at [i*LEN_BITS +: LEN_BITS]
m_req_valid  out  1  forwarded request valid
m_req_ready  in  1  downstream accept
m_req_dest  out  clog2(N_DESTS) min 1  granted destination index
m_req_len  out  LEN_BITS  granted request length
xfer  in  N_DESTS  one response beat consumed from dest i's response FIFO this cycle
err_oversize  out  N_DESTS  sticky: dest i submitted a request larger than CRED_MAX beats

Behaviour:
- Reset, asynchronous, aresetn low:
  - all credits = CRED_MAX; state IDLE; round-robin pointer = 0.
  - m_req_valid = 0; m_req_dest = 0; m_req_len = 0; s_req_ready = 0; err_oversize = 0.
- beats(len) = ceil(len/64) = (len + 63) >> 6, computed at LEN_BITS+1 width. len = 0 counts as 1 beat.
- eligible[i] = s_req_valid[i] and beats(len_i) <= cred[i].
- oversize[i] = s_req_valid[i] and beats(len_i) > CRED_MAX.
- State IDLE:
  - If any oversize[i], the lowest such i is handled in this cycle: s_req_ready[i] = 1 for one cycle, the request is dropped, err_oversize[i] sets. Stay IDLE.
  - Otherwise, if any eligible: pick the first eligible index at or after the pointer, wrapping.
    - Pulse s_req_ready[g] for one cycle.
    - Register dest and len into the m_req_* outputs.
    - cred[g] -= beats.
    - Pointer = g+1 mod N_DESTS.
    - Go to SEND.
- State SEND:
  - m_req_valid = 1; outputs held stable.
  - When m_req_ready = 1: deassert m_req_valid next cycle, go to IDLE.
  - No new grant in the same cycle. Maximum throughput is one request per 2 cycles.
- Latency: eligible request in cycle t gives m_req_valid in cycle t+1.
- Credit update every cycle: cred[i] next = cred[i] - (grant beats if i granted) + xfer[i].
  - Simultaneous grant and xfer on the same destination net out in one update.
  - Result never exceeds CRED_MAX. xfer at full credit is ignored and flagged by a simulation assertion.
  - Width is clog2(CRED_MAX+1).
- A destination that is not eligible does not block the others; a starved head-of-line request waits.
- s_req_len must be stable while s_req_valid is high and not yet accepted.
- err_oversize clears only on reset.

Optional Feature:
- RD_CRED_STATS_EN defined:
  - Adds output stall_cnt, N_DESTS*32 bits, packed.
  - stall_cnt[i] increments in each IDLE cycle where s_req_valid[i] = 1 and beats(len_i) > cred[i] and not oversize[i].
  - Saturates at 2^32-1; reset to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- lynxTypes:
  - new constant RD_CRED_BEAT_BYTES = 64 (beat shift 6).
  - typedef rd_sched_state_t {IDLE, SEND}.
- Sub-module rd_cred_rr_arb: combinational N-way round-robin priority pick (request vector, pointer in; grant index and any-grant out). The top level owns the pointer register, credits and FSM.

Test Plan:
1. Reset, then dest0 len=128 -> m_req_valid in cycle +1 with dest=0, len=128; cred[0]=510 after grant; back in IDLE after m_req_ready.
2. dests 0,1,2 all valid len=64 continuously, m_req_ready=1 -> grant order 0,1,2,0,1,2, one grant per 2 cycles.
3. cred[1] drained to 3, dest1 len=256 (4 beats), dest2 len=64 valid -> dest2 granted, dest1 held. One xfer[1] pulse -> dest1 granted next IDLE; cred[1]=0.
4. Grant of 2 beats to dest0 in the same cycle as xfer[0]=1 at cred=512 -> cred[0]=511.
5. dest3 len=CRED_MAX*64+1 -> s_req_ready[3] pulses, no m_req_valid, err_oversize[3]=1 and sticky.
6. aresetn low while in SEND with m_req_ready=0 -> m_req_valid=0 immediately, all credits 512. With RD_CRED_STATS_EN, a 5-cycle credit stall gives stall_cnt[i]=5.
